// File: rtl/dmem_arbiter.sv
// Two-port (core C, loader D) arbiter for the single-port data memory: core priority
// with an aging counter for D, plus registered one-cycle responses. Optional DMEM_ARB_ALIGN_CHECK_EN.

module dmem_arb_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  grant,
  input  logic                  load,
  input  logic                  err,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= grant;
      // data/err hold between responses; only a grant reloads them
      if (grant) begin
        rsp_rdata <= (load && !err) ? rdata : '0;
        rsp_err   <= err;
      end
    end
  end
endmodule

module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     c_valid,
  input  logic                     d_valid,
  input  logic                     c_we,
  input  logic                     d_we,
  input  logic [2:0]               c_funct3,
  input  logic [2:0]               d_funct3,
  input  logic [ADDRESS_WIDTH-1:0] c_addr,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    c_wdata,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     c_ready,
  output logic                     d_ready,
  output logic                     c_stall,
  output logic                     c_rsp_valid,
  output logic                     d_rsp_valid,
  output logic [DATA_WIDTH-1:0]    c_rsp_rdata,
  output logic [DATA_WIDTH-1:0]    d_rsp_rdata,
  output logic                     c_rsp_err,
  output logic                     d_rsp_err,
  output logic                     mem_write,
  output logic [2:0]               mem_funct3,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);
  localparam int NUM_PORTS = 2;  // index 0 = C, 1 = D

  typedef struct packed {
    logic                     we;
    logic [2:0]               funct3;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
  } req_t;

  req_t [NUM_PORTS-1:0]                 req;
  req_t                                 sel;
  logic [NUM_PORTS-1:0]                 valid, grant, err, wr_ok;
  logic [NUM_PORTS-1:0]                 rsp_valid, rsp_err;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_rdata;
  logic [7:0]                           wait_cnt;
  logic                                 force_d;

  assign req[0] = '{we: c_we, funct3: c_funct3, addr: c_addr, wdata: c_wdata};
  assign req[1] = '{we: d_we, funct3: d_funct3, addr: d_addr, wdata: d_wdata};
  assign valid  = {d_valid, c_valid};

  assign force_d  = (wait_cnt == 8'(STARVE_LIMIT));
  assign grant[0] = valid[0] & (~valid[1] | ~force_d);
  assign grant[1] = valid[1] & (~valid[0] | force_d);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101:         misaligned = a[0];
      3'b010:                 misaligned = |a;
      3'b011, 3'b110, 3'b111: misaligned = 1'b1;
      default:                misaligned = 1'b0;
    endcase
  endfunction
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign err[p] = misaligned(req[p].funct3, req[p].addr[1:0]);
`else
    assign err[p] = 1'b0;
`endif
    assign wr_ok[p] = grant[p] & req[p].we & ~err[p];

    dmem_arb_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant     (grant[p]),
      .load      (~req[p].we),
      .err       (err[p]),
      .rdata     (mem_rdata),
      .rsp_valid (rsp_valid[p]),
      .rsp_rdata (rsp_rdata[p]),
      .rsp_err   (rsp_err[p])
    );
  end

  // with no grant the mux falls through to C, keeping mem_* on the core inputs
  assign sel        = grant[1] ? req[1] : req[0];
  assign mem_funct3 = sel.funct3;
  assign mem_addr   = sel.addr;
  assign mem_wdata  = sel.wdata;
  assign mem_write  = rst_n & (|wr_ok);

  assign c_ready     = grant[0];
  assign d_ready     = grant[1];
  assign c_stall     = c_valid & ~grant[0];
  assign c_rsp_valid = rsp_valid[0];
  assign d_rsp_valid = rsp_valid[1];
  assign c_rsp_rdata = rsp_rdata[0];
  assign d_rsp_rdata = rsp_rdata[1];
  assign c_rsp_err   = rsp_err[0];
  assign d_rsp_err   = rsp_err[1];

  // counter restarts after a forced grant, so D gets one slot per STARVE_LIMIT+1 cycles
  always_ff @(posedge clk) begin
    if (!rst_n)                    wait_cnt <= 8'd0;
    else if (grant[1] || !d_valid) wait_cnt <= 8'd0;
    else if (!force_d)             wait_cnt <= wait_cnt + 8'd1;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed behavioural memory
// (async read with size/sign extraction, store merging at posedge).

module tb_dmem_arbiter;
  logic        clk, rst_n;
  logic        c_valid, d_valid, c_we, d_we;
  logic [2:0]  c_funct3, d_funct3;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic        c_ready, d_ready, c_stall;
  logic        c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err;
  logic [31:0] c_rsp_rdata, d_rsp_rdata;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:255];

  dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .d_valid(d_valid), .c_we(c_we), .d_we(d_we),
    .c_funct3(c_funct3), .d_funct3(d_funct3), .c_addr(c_addr), .d_addr(d_addr),
    .c_wdata(c_wdata), .d_wdata(d_wdata),
    .c_ready(c_ready), .d_ready(d_ready), .c_stall(c_stall),
    .c_rsp_valid(c_rsp_valid), .d_rsp_valid(d_rsp_valid),
    .c_rsp_rdata(c_rsp_rdata), .d_rsp_rdata(d_rsp_rdata),
    .c_rsp_err(c_rsp_err), .d_rsp_err(d_rsp_err),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model
  always_comb begin
    logic [7:0] a;
    a = mem_addr[7:0];
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{mem[a][7]}}, mem[a]};
      3'b001:  mem_rdata = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      3'b100:  mem_rdata = {24'd0, mem[a]};
      3'b101:  mem_rdata = {16'd0, mem[a+8'd1], mem[a]};
      default: mem_rdata = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[mem_addr[7:0]+8'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[mem_addr[7:0]+8'd2] <= mem_wdata[23:16];
        mem[mem_addr[7:0]+8'd3] <= mem_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] memword(input logic [7:0] a);
    return {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_valid = 0; d_valid = 0; c_we = 0; d_we = 0;
    c_funct3 = 3'b010; d_funct3 = 3'b010;
    c_addr = 0; d_addr = 0; c_wdata = 0; d_wdata = 0;
  endtask

  task automatic c_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    c_valid = 1; c_we = we; c_funct3 = f3; c_addr = a; c_wdata = wd;
  endtask

  task automatic d_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    d_valid = 1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    logic exp_b;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    idle();

    // reset with a store presented: must not reach memory
    rst_n = 0;
    c_req(1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    chk("rst_mem_write", {31'd0, mem_write}, 0);
    step();
    @(negedge clk);
    chk("rst_c_rsp_valid", {31'd0, c_rsp_valid}, 0);
    chk("rst_c_rsp_rdata", c_rsp_rdata, 0);
    chk("rst_c_rsp_err",   {31'd0, c_rsp_err}, 0);
    chk("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 0);
    chk("rst_d_rsp_rdata", d_rsp_rdata, 0);
    step();
    rst_n = 1; idle();
    @(negedge clk);
    chk("rst_no_store", memword(8'h40), 0);
    chk("idle_mem_write", {31'd0, mem_write}, 0);
    chk("idle_ready", {30'd0, c_ready, d_ready}, 0);
    step();

    // C sw then C lw same address
    c_req(1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_mem_write", {31'd0, mem_write}, 1);
    chk("sw_c_ready",   {31'd0, c_ready}, 1);
    chk("sw_mem_addr",  mem_addr, 32'h10);
    step();
    c_req(0, 3'b010, 32'h10, 0);
    @(negedge clk);
    chk("lw_mem_write",   {31'd0, mem_write}, 0);
    chk("sw_rsp_valid",   {31'd0, c_rsp_valid}, 1);
    chk("sw_rsp_rdata",   c_rsp_rdata, 0);
    step();
    idle();
    @(negedge clk);
    chk("lw_rsp_valid", {31'd0, c_rsp_valid}, 1);
    chk("lw_rsp_rdata", c_rsp_rdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("rsp_pulse_end", {31'd0, c_rsp_valid}, 0);
    chk("rsp_rdata_hold", c_rsp_rdata, 32'hDEADBEEF);

    // C stores 0x0000A500, then D-only lbu 0x11
    c_req(1, 3'b010, 32'h10, 32'h0000A500);
    step();
    idle();
    d_req(0, 3'b100, 32'h11, 0);
    @(negedge clk);
    chk("lbu_d_ready", {31'd0, d_ready}, 1);
    chk("lbu_c_ready", {31'd0, c_ready}, 0);
    chk("lbu_mem_addr", mem_addr, 32'h11);
    step();
    idle();
    @(negedge clk);
    chk("lbu_d_rsp_valid", {31'd0, d_rsp_valid}, 1);
    chk("lbu_d_rsp_rdata", d_rsp_rdata, 32'h000000A5);
    chk("lbu_c_rsp_valid", {31'd0, c_rsp_valid}, 0);
    step();

    // continuous contention: D forced every 5th cycle
    c_req(0, 3'b010, 32'h10, 0);
    d_req(0, 3'b010, 32'h20, 0);
    for (int k = 1; k <= 15; k++) begin
      exp_b = (k % 5 == 0);
      @(negedge clk);
      chk("starve_d_ready", {31'd0, d_ready}, {31'd0, exp_b});
      chk("starve_c_stall", {31'd0, c_stall}, {31'd0, exp_b});
      chk("starve_c_ready", {31'd0, c_ready}, {31'd0, !exp_b});
      if (k > 1) chk("starve_d_rsp", {31'd0, d_rsp_valid}, {31'd0, ((k - 1) % 5 == 0)});
      step();
    end
    idle();

    // lw accepted, then reset cycle with a store presented
    c_req(0, 3'b010, 32'h10, 0);
    @(negedge clk);
    chk("pre_rst_c_ready", {31'd0, c_ready}, 1);
    step();
    rst_n = 0;
    c_req(1, 3'b010, 32'h10, 32'h55555555);
    @(negedge clk);
    chk("rst2_mem_write", {31'd0, mem_write}, 0);
    chk("rst2_rsp_before", c_rsp_rdata, 32'h0000A500);
    step();
    rst_n = 1; idle();
    @(negedge clk);
    chk("rst2_c_rsp_valid", {31'd0, c_rsp_valid}, 0);
    chk("rst2_c_rsp_rdata", c_rsp_rdata, 0);
    chk("rst2_mem_intact", memword(8'h10), 32'h0000A500);
    step();

    // misaligned halfword store
    c_req(1, 3'b001, 32'h13, 32'h00001234);
    @(negedge clk);
    chk("mis_c_ready", {31'd0, c_ready}, 1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("mis_mem_write", {31'd0, mem_write}, 0);
`else
    chk("mis_mem_write", {31'd0, mem_write}, 1);
`endif
    step();
    idle();
    @(negedge clk);
    chk("mis_rsp_valid", {31'd0, c_rsp_valid}, 1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("mis_rsp_err", {31'd0, c_rsp_err}, 1);
    chk("mis_word", memword(8'h10), 32'h0000A500);
`else
    chk("mis_rsp_err", {31'd0, c_rsp_err}, 0);
    chk("mis_word", memword(8'h10), 32'h3400A500);
    chk("mis_byte14", {24'd0, mem[8'h14]}, 32'h12);
`endif
    step();

    // D store followed by C load of the same word
    d_req(1, 3'b010, 32'h20, 32'h11111111);
    @(negedge clk);
    chk("fwd_d_ready", {31'd0, d_ready}, 1);
    chk("fwd_mem_write", {31'd0, mem_write}, 1);
    step();
    idle();
    c_req(0, 3'b010, 32'h20, 0);
    @(negedge clk);
    chk("fwd_c_ready", {31'd0, c_ready}, 1);
    chk("fwd_d_rsp_valid", {31'd0, d_rsp_valid}, 1);
    step();
    idle();
    @(negedge clk);
    chk("fwd_c_rsp_valid", {31'd0, c_rsp_valid}, 1);
    chk("fwd_c_rsp_rdata", c_rsp_rdata, 32'h11111111);
    chk("fwd_d_rsp_end", {31'd0, d_rsp_valid}, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
